// File: rtl/mystic_div_pkg.sv
// Shared state encoding, funct3 codes and default widths for the divide sequencer.
package mystic_div_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int TAG_W_DEFAULT = 5;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ISSUE = 5'b00010,
    S_WAIT  = 5'b00100,
    S_DRAIN = 5'b01000,
    S_RESP  = 5'b10000
  } state_e;

endpackage

// File: rtl/mystic_div_prep.sv
// Operand extension and RISC-V divide special-case detection (divide-by-zero,
// signed overflow) with the architecturally defined quotient/remainder.
module mystic_div_prep
  import mystic_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            unsigned_op,
  input  logic            word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            signed_op,
  output logic [XLEN-1:0] upper,
  output logic [XLEN-1:0] lower,
  output logic            div_zero,
  output logic            overflow,
  output logic [XLEN-1:0] special_quot,
  output logic [XLEN-1:0] special_rem
);

  logic [XLEN-1:0] min_val;

  always_comb begin
    signed_op = ~unsigned_op;
    if (word) begin
      upper   = signed_op ? {{(XLEN-32){rs1[31]}}, rs1[31:0]} : {{(XLEN-32){1'b0}}, rs1[31:0]};
      lower   = signed_op ? {{(XLEN-32){rs2[31]}}, rs2[31:0]} : {{(XLEN-32){1'b0}}, rs2[31:0]};
      // Most negative 32-bit value as it appears after sign extension
      min_val = {{(XLEN-32){1'b1}}, 1'b1, 31'b0};
    end else begin
      upper   = rs1;
      lower   = rs2;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    div_zero     = (lower == '0);
    overflow     = signed_op && (upper == min_val) && (lower == '1);
    special_quot = div_zero ? '1 : upper;
    special_rem  = div_zero ? upper : '0;
  end

endmodule

// File: rtl/mystic_div_ctrl.sv
// Sequencer between M-extension issue and the iterative divider.
// Define MYSTIC_DIV_REUSE_EN to reuse the last divider result for matching operands.
module mystic_div_ctrl
  import mystic_div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic             req_word_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             resp_err_o,
  output logic             div_enable_o,
  output logic             div_upper_signed_o,
  output logic             div_lower_signed_o,
  output logic [XLEN-1:0]  div_upper_o,
  output logic [XLEN-1:0]  div_lower_o,
  input  logic [XLEN-1:0]  div_result_i,
  input  logic [XLEN-1:0]  div_rem_i,
  input  logic             div_ready_i,
  input  logic             div_exception_i
);

  state_e state_reg, state_next;

  logic [TAG_W-1:0] tag_reg;
  logic             sel_rem_reg, word_reg, signed_reg, err_reg;
  logic [XLEN-1:0]  upper_reg, lower_reg, quot_reg, rem_reg;

  logic            prep_signed, prep_zero, prep_ovf, prep_special;
  logic [XLEN-1:0] prep_upper, prep_lower, prep_quot, prep_rem;
  logic            accept, reuse_hit, div_done, f3_unused;
  logic [XLEN-1:0] sel_data;

  // funct3[2] is always set for the divide group, so it carries no information
  assign f3_unused = req_funct3_i[2];

  mystic_div_prep #(.XLEN(XLEN)) u_prep (
    .unsigned_op  (req_funct3_i[0]),
    .word         (req_word_i),
    .rs1          (req_rs1_i),
    .rs2          (req_rs2_i),
    .signed_op    (prep_signed),
    .upper        (prep_upper),
    .lower        (prep_lower),
    .div_zero     (prep_zero),
    .overflow     (prep_ovf),
    .special_quot (prep_quot),
    .special_rem  (prep_rem)
  );

  assign prep_special = prep_zero | prep_ovf;
  assign req_ready_o  = (state_reg == S_IDLE) && !rst_i;
  assign accept       = req_valid_i && req_ready_o;
  // A flush coinciding with the ready pulse discards the result
  assign div_done     = (state_reg == S_WAIT) && div_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    div_enable_o = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) state_next = (prep_special || reuse_hit) ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        div_enable_o = 1'b1;
        state_next   = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush_i)          state_next = div_ready_i ? S_IDLE : S_DRAIN;
        else if (div_ready_i) state_next = S_RESP;
      end
      S_DRAIN: begin
        if (div_ready_i) state_next = S_IDLE;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (flush_i || resp_ready_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef MYSTIC_DIV_REUSE_EN
  logic            cache_valid_reg, cache_signed_reg;
  logic [XLEN-1:0] cache_upper_reg, cache_lower_reg, cache_quot_reg, cache_rem_reg;

  assign reuse_hit = cache_valid_reg && (cache_signed_reg == prep_signed) &&
                     (cache_upper_reg == prep_upper) && (cache_lower_reg == prep_lower);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cache_valid_reg  <= 1'b0;
      cache_signed_reg <= 1'b0;
      cache_upper_reg  <= '0;
      cache_lower_reg  <= '0;
      cache_quot_reg   <= '0;
      cache_rem_reg    <= '0;
    end else if (div_done) begin
      cache_valid_reg  <= !div_exception_i;
      cache_signed_reg <= signed_reg;
      cache_upper_reg  <= upper_reg;
      cache_lower_reg  <= lower_reg;
      cache_quot_reg   <= div_result_i;
      cache_rem_reg    <= div_rem_i;
    end else if ((state_reg == S_WAIT || state_reg == S_DRAIN) && div_ready_i) begin
      cache_valid_reg <= 1'b0;
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_reg     <= '0;
      sel_rem_reg <= 1'b0;
      word_reg    <= 1'b0;
      signed_reg  <= 1'b0;
      err_reg     <= 1'b0;
      upper_reg   <= '0;
      lower_reg   <= '0;
      quot_reg    <= '0;
      rem_reg     <= '0;
    end else begin
      if (accept) begin
        tag_reg     <= req_tag_i;
        sel_rem_reg <= req_funct3_i[1];
        word_reg    <= req_word_i;
        signed_reg  <= prep_signed;
        err_reg     <= 1'b0;
        upper_reg   <= prep_upper;
        lower_reg   <= prep_lower;
        if (prep_special) begin
          quot_reg <= prep_quot;
          rem_reg  <= prep_rem;
        end
`ifdef MYSTIC_DIV_REUSE_EN
        else if (reuse_hit) begin
          quot_reg <= cache_quot_reg;
          rem_reg  <= cache_rem_reg;
        end
`endif
      end
      if (div_done) begin
        quot_reg <= div_result_i;
        rem_reg  <= div_rem_i;
        err_reg  <= div_exception_i;
      end
    end
  end

  assign div_upper_o        = upper_reg;
  assign div_lower_o        = lower_reg;
  assign div_upper_signed_o = signed_reg;
  assign div_lower_signed_o = signed_reg;

  // W results are always sign-extended from bit 31, including DIVUW/REMUW
  assign sel_data    = sel_rem_reg ? rem_reg : quot_reg;
  assign resp_data_o = word_reg ? {{(XLEN-32){sel_data[31]}}, sel_data[31:0]} : sel_data;
  assign resp_tag_o  = tag_reg;
  assign resp_err_o  = err_reg;

endmodule

// File: tb/tb_mystic_div_ctrl.sv
// Self-checking bench for mystic_div_ctrl with a behavioural divider and an
// arithmetic reference for RISC-V divide/remainder results.
module tb_mystic_div_ctrl;
  import mystic_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i = 3'b100;
  logic        req_word_i = 1'b0;
  logic [63:0] req_rs1_i = '0;
  logic [63:0] req_rs2_i = '0;
  logic [4:0]  req_tag_i = '0;
  logic        flush_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [63:0] resp_data_o;
  logic [4:0]  resp_tag_o;
  logic        resp_err_o;
  logic        div_enable_o;
  logic        div_upper_signed_o;
  logic        div_lower_signed_o;
  logic [63:0] div_upper_o;
  logic [63:0] div_lower_o;
  logic [63:0] div_result_i = '0;
  logic [63:0] div_rem_i = '0;
  logic        div_ready_i = 1'b0;
  logic        div_exception_i = 1'b0;

  always #5 clk = ~clk;

  mystic_div_ctrl #(.XLEN(64), .TAG_W(5)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_funct3_i       (req_funct3_i),
    .req_word_i         (req_word_i),
    .req_rs1_i          (req_rs1_i),
    .req_rs2_i          (req_rs2_i),
    .req_tag_i          (req_tag_i),
    .flush_i            (flush_i),
    .resp_valid_o       (resp_valid_o),
    .resp_ready_i       (resp_ready_i),
    .resp_data_o        (resp_data_o),
    .resp_tag_o         (resp_tag_o),
    .resp_err_o         (resp_err_o),
    .div_enable_o       (div_enable_o),
    .div_upper_signed_o (div_upper_signed_o),
    .div_lower_signed_o (div_lower_signed_o),
    .div_upper_o        (div_upper_o),
    .div_lower_o        (div_lower_o),
    .div_result_i       (div_result_i),
    .div_rem_i          (div_rem_i),
    .div_ready_i        (div_ready_i),
    .div_exception_i    (div_exception_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Divider model: answers div_lat cycles after an enable pulse
  int          div_lat = 2;
  bit          div_exc_next = 1'b0;
  int          div_pulses = 0;
  int          div_cnt = 0;
  logic [63:0] mdl_q, mdl_r, last_up, last_lo;
  logic        last_us, last_ls;

  // Reuse-cache model: operands of the last clean divider completion
  bit          c_valid = 1'b0;
  logic [63:0] c_up, c_lo;
  logic        c_sg;

  always @(posedge clk) begin
    #1;
    div_ready_i     = 1'b0;
    div_exception_i = 1'b0;
    if (rst_i) div_cnt = 0;
    else begin
      if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0) begin
          div_ready_i     = 1'b1;
          div_result_i    = mdl_q;
          div_rem_i       = mdl_r;
          div_exception_i = div_exc_next;
        end
      end
      if (div_enable_o === 1'b1) begin
        div_pulses++;
        last_up = div_upper_o;
        last_lo = div_lower_o;
        last_us = div_upper_signed_o;
        last_ls = div_lower_signed_o;
        if (last_lo == 64'd0) begin
          mdl_q = '1; mdl_r = last_up;
        end else if (last_us && last_up == 64'h8000_0000_0000_0000 && last_lo == '1) begin
          mdl_q = last_up; mdl_r = '0;
        end else if (last_us) begin
          mdl_q = $signed(last_up) / $signed(last_lo);
          mdl_r = $signed(last_up) % $signed(last_lo);
        end else begin
          mdl_q = last_up / last_lo;
          mdl_r = last_up % last_lo;
        end
        div_cnt = div_lat;
      end
    end
  end

  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic        sg, rem;
    logic [31:0] a32, b32, q32, r32, res32;
    logic [63:0] q, r;
    sg = !f3[0];
    rem = f3[1];
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin q32 = '1; r32 = a32; end
      else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = '0; end
      else if (sg) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      res32 = rem ? r32 : q32;
      return {{32{res32[31]}}, res32};
    end
    if (b == 64'd0) begin q = '1; r = a; end
    else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; end
    else if (sg) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else begin q = a / b; r = a % b; end
    return rem ? r : q;
  endfunction

  function automatic logic [63:0] prep_op(input logic w, input logic sg, input logic [63:0] x);
    if (!w) return x;
    return sg ? {{32{x[31]}}, x[31:0]} : {32'd0, x[31:0]};
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    logic sg;
    sg = !f3[0];
    if (w) return (b[31:0] == 32'd0) || (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (sg && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic bit expect_pulse(input logic [2:0] f3, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    if (is_special(f3, w, a, b)) return 1'b0;
`ifdef MYSTIC_DIV_REUSE_EN
    if (c_valid && c_sg == !f3[0] && c_up == prep_op(w, !f3[0], a) && c_lo == prep_op(w, !f3[0], b))
      return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic send_req(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag);
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_funct3_i = f3;
    req_word_i   = w;
    req_rs1_i    = a;
    req_rs2_i    = b;
    req_tag_i    = tag;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_rs1_i   = {$urandom, $urandom};
    req_rs2_i   = {$urandom, $urandom};
    req_tag_i   = 5'($urandom);
  endtask

  // Drives one request and returns what was observed; lat counts cycles after
  // acceptance (0 = valid on the first cycle after the accepting edge), -1 on timeout.
  task automatic run_txn(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, input int hold,
                         output logic [63:0] d, output logic [4:0] t, output logic e,
                         output int lat, output int pulses, output bit stable);
    int p0;
    p0 = div_pulses;
    send_req(f3, w, a, b, tag);
    lat = 0;
    while (resp_valid_o !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (resp_valid_o !== 1'b1) lat = -1;
    d = resp_data_o;
    t = resp_tag_o;
    e = resp_err_o;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid_o !== 1'b1 || resp_data_o !== d || resp_tag_o !== t ||
          resp_err_o !== e || req_ready_o !== 1'b0) stable = 1'b0;
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    pulses = div_pulses - p0;
    if (pulses > 0 && lat >= 0) begin
      if (div_exc_next) c_valid = 1'b0;
      else begin
        c_valid = 1'b1; c_up = last_up; c_lo = last_lo; c_sg = last_us;
      end
    end
    $display("txn f3=%b w=%0d rs1=%h rs2=%h tag=%0d -> data=%h tag=%0d err=%0d lat=%0d pulses=%0d",
             f3, w, a, b, tag, d, t, e, lat, pulses);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0 || div_enable_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl got ready=%b valid=%b en=%b exp 0 0 0", req_ready_o, resp_valid_o, div_enable_o);
    end
    n_checks++;
    if (resp_data_o !== 64'd0 || resp_tag_o !== 5'd0 || resp_err_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_resp got data=%h tag=%0d err=%b exp 0", resp_data_o, resp_tag_o, resp_err_o);
    end
    n_checks++;
    if (div_upper_o !== 64'd0 || div_lower_o !== 64'd0 || div_upper_signed_o !== 1'b0 || div_lower_signed_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_div got up=%h lo=%h sg=%b%b exp 0", div_upper_o, div_lower_o, div_upper_signed_o, div_lower_signed_o);
    end
    rst_i = 1'b0;
    c_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_idle_ready got=%b exp=1", req_ready_o);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic test_plan_vectors();
    vec_t        v [7];
    logic [63:0] d;
    logic [4:0]  t;
    logic        e;
    int          lat, pulses;
    bit          stable, ep;
    v[0] = '{F3_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA};
    v[1] = '{F3_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    v[2] = '{F3_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234};
    v[3] = '{F3_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
    v[4] = '{F3_REM,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 64'd0};
    v[5] = '{F3_REMU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF};
    v[6] = '{F3_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF};
    div_lat = 3;
    for (int i = 0; i < 7; i++) begin
      ep = expect_pulse(v[i].f3, v[i].w, v[i].a, v[i].b);
      run_txn(v[i].f3, v[i].w, v[i].a, v[i].b, 5'(i + 3), 0, d, t, e, lat, pulses, stable);
      n_checks++;
      if (d !== v[i].exp) begin
        n_errors++;
        $display("FAIL plan%0d_data got=%h exp=%h", i, d, v[i].exp);
      end
      n_checks++;
      if (t !== 5'(i + 3)) begin
        n_errors++;
        $display("FAIL plan%0d_tag got=%0d exp=%0d", i, t, i + 3);
      end
      n_checks++;
      if (pulses != int'(ep) || lat != (ep ? div_lat + 1 : 0)) begin
        n_errors++;
        $display("FAIL plan%0d_path got pulses=%0d lat=%0d exp pulses=%0d", i, pulses, lat, ep);
      end
      if (ep) begin
        n_checks++;
        if (last_up !== prep_op(v[i].w, !v[i].f3[0], v[i].a) || last_lo !== prep_op(v[i].w, !v[i].f3[0], v[i].b) ||
            last_us !== !v[i].f3[0] || last_ls !== !v[i].f3[0]) begin
          n_errors++;
          $display("FAIL plan%0d_operands got up=%h lo=%h sg=%b%b", i, last_up, last_lo, last_us, last_ls);
        end
      end
    end
  endtask

  task automatic test_hold_reuse();
    logic [63:0] a, d;
    logic [4:0]  t;
    logic        e;
    int          lat, pulses;
    bit          stable, ep;
    a = 64'd1000 + 64'($urandom_range(0, 5000));
    div_lat = 2;
    run_txn(F3_DIV, 1'b0, a, 64'd7, 5'd9, 4, d, t, e, lat, pulses, stable);
    n_checks++;
    if (stable !== 1'b1 || d !== a / 64'd7) begin
      n_errors++;
      $display("FAIL hold_stable got stable=%0d data=%h exp data=%h", stable, d, a / 64'd7);
    end
    ep = expect_pulse(F3_REM, 1'b0, a, 64'd7);
    run_txn(F3_REM, 1'b0, a, 64'd7, 5'd10, 0, d, t, e, lat, pulses, stable);
    n_checks++;
    if (d !== a % 64'd7 || pulses != int'(ep) || lat != (ep ? div_lat + 1 : 0)) begin
      n_errors++;
      $display("FAIL reuse_rem got data=%h pulses=%0d lat=%0d exp data=%h pulses=%0d", d, pulses, lat, a % 64'd7, ep);
    end
  endtask

  task automatic test_flush_busy();
    bit seen, early, bad_valid;
    int p0;
    div_lat = 6;
    for (int stage = 0; stage < 2; stage++) begin
      p0 = div_pulses;
      send_req(F3_DIVU, 1'b0, 64'd5000, 64'd9, 5'd17);
      if (stage == 1) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      seen = 1'b0; early = 1'b0; bad_valid = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
        if (resp_valid_o !== 1'b0) bad_valid = 1'b1;
        if (req_ready_o !== 1'b0) early = 1'b1;
        if (div_ready_i === 1'b1) seen = 1'b1;
        else @(negedge clk);
      end
      @(negedge clk);
      c_valid = 1'b0;
      n_checks++;
      if (!seen || early || bad_valid) begin
        n_errors++;
        $display("FAIL flush%0d_drain got seen=%0d early_ready=%0d valid=%0d exp 1 0 0", stage, seen, early, bad_valid);
      end
      n_checks++;
      if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
        n_errors++;
        $display("FAIL flush%0d_idle got ready=%b valid=%b exp 1 0", stage, req_ready_o, resp_valid_o);
      end
      n_checks++;
      if (div_pulses - p0 != 1) begin
        n_errors++;
        $display("FAIL flush%0d_pulse got=%0d exp=1", stage, div_pulses - p0);
      end
    end
  endtask

  task automatic test_flush_resp();
    send_req(F3_DIVU, 1'b0, 64'h55, 64'd0, 5'd4);
    n_checks++;
    if (resp_valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_resp_valid got=%b exp=1", resp_valid_o);
    end
    flush_i = 1'b1;
    resp_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    resp_ready_i = 1'b0;
    n_checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_resp_drop got valid=%b ready=%b exp 0 1", resp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_exception();
    logic [63:0] d;
    logic [4:0]  t;
    logic        e;
    int          lat, pulses;
    bit          stable;
    div_lat = 2;
    div_exc_next = 1'b1;
    run_txn(F3_DIV, 1'b0, 64'd100, 64'd7, 5'd21, 1, d, t, e, lat, pulses, stable);
    div_exc_next = 1'b0;
    n_checks++;
    if (e !== 1'b1 || d !== 64'd14 || stable !== 1'b1) begin
      n_errors++;
      $display("FAIL exc_flag got err=%b data=%h stable=%0d exp 1 e 1", e, d, stable);
    end
    run_txn(F3_REM, 1'b0, 64'd100, 64'd7, 5'd22, 0, d, t, e, lat, pulses, stable);
    n_checks++;
    if (e !== 1'b0 || d !== 64'd2 || pulses != 1) begin
      n_errors++;
      $display("FAIL exc_clears got err=%b data=%h pulses=%0d exp 0 2 1", e, d, pulses);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b, pa, pb, d, exp;
    logic [4:0]  t, tag;
    logic        e;
    int          lat, pulses, hold;
    bit          stable, ep;
    pa = 64'd77; pb = 64'd5;
    for (int n = 0; n < 40; n++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = w ? {$urandom, 32'd0} : 64'd0;
        1: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
        end
        2: begin a = pa; b = pb; end
        3: b = 64'($urandom_range(1, 300));
        default: ;
      endcase
      tag = 5'($urandom);
      hold = $urandom_range(0, 3);
      div_lat = $urandom_range(1, 5);
      exp = ref_result(f3, w, a, b);
      ep = expect_pulse(f3, w, a, b);
      run_txn(f3, w, a, b, tag, hold, d, t, e, lat, pulses, stable);
      pa = a; pb = b;
      n_checks++;
      if (d !== exp) begin
        n_errors++;
        $display("FAIL rnd%0d_data f3=%b w=%0d got=%h exp=%h", n, f3, w, d, exp);
      end
      n_checks++;
      if (t !== tag || e !== 1'b0) begin
        n_errors++;
        $display("FAIL rnd%0d_tag got tag=%0d err=%b exp tag=%0d err=0", n, t, e, tag);
      end
      n_checks++;
      if (pulses != int'(ep)) begin
        n_errors++;
        $display("FAIL rnd%0d_pulses got=%0d exp=%0d", n, pulses, ep);
      end
      n_checks++;
      if (lat != (ep ? div_lat + 1 : 0)) begin
        n_errors++;
        $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, lat, ep ? div_lat + 1 : 0);
      end
      n_checks++;
      if (stable !== 1'b1) begin
        n_errors++;
        $display("FAIL rnd%0d_hold got stable=%0d exp=1", n, stable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_hold_reuse();
    test_flush_busy();
    test_flush_resp();
    test_exception();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
